// File: rtl/floor_request_queue.sv
// SCAN request queue: synchronizes and edge-detects floor buttons, latches pending calls and picks the next target.
// Optional feature macro: REQ_DEBOUNCE_EN (per-button consecutive-high debounce counter after the synchronizer).
module floor_request_queue #(
    parameter int FLOORS = 4
`ifdef REQ_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 3
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] call_up,
    input  logic [3:0] call_down,
    input  logic [3:0] car_call,
    input  logic [1:0] level,
    input  logic       arrived,
    output logic [1:0] target,
    output logic       target_valid,
    output logic [1:0] dir,
    output logic [3:0] pending
);
    localparam int NB = 3 * FLOORS;

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_UP = 2'b01, S_DOWN = 2'b10} dir_e;

    logic [NB-1:0] w_btn, r_sync1, r_sync2, w_level_ok, r_prev, r_edge, w_set;
    logic [3:0]    r_up_q, r_dn_q, r_car_q, w_pend;
    logic [3:0]    w_clr_up, w_clr_dn, w_clr_car;
    logic          w_above, w_below, w_here, w_up_hit, w_dn_hit;
    logic [1:0]    w_up_pri, w_up_alt, w_dn_pri, w_dn_alt, w_up_tgt, w_dn_tgt;
    dir_e          r_state;
    logic [1:0]    r_target;
    logic          r_valid;

    // Top floor has no up button and ground floor has no down button.
    assign w_btn = {car_call, call_down & 4'b1110, call_up & 4'b0111};

    // Two-flop synchronizer followed by a registered rising-edge detector
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_edge  <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_prev  <= w_level_ok;
            r_edge  <= w_level_ok & ~r_prev;
        end
    end

`ifdef REQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] r_cnt [NB];

    // Saturating count of consecutive high synchronized samples per button
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (reset || !r_sync2[i]) begin
                r_cnt[i] <= '0;
            end else if (r_cnt[i] != CW'(DEBOUNCE_CYCLES)) begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
            end else begin
                r_cnt[i] <= r_cnt[i];
            end
        end
    end

    // A button counts as pressed once its counter has saturated
    always_comb begin
        w_level_ok = '0;
        for (int i = 0; i < NB; i++) begin
            w_level_ok[i] = (r_cnt[i] == CW'(DEBOUNCE_CYCLES));
        end
    end
`else
    assign w_level_ok = r_sync2;
`endif

    assign w_set  = enable ? r_edge : '0;
    assign w_pend = r_up_q | r_dn_q | r_car_q;
    assign w_here = w_pend[level];

    // Arrival clears the served calls; a hall call against the travel direction survives
    always_comb begin
        w_clr_up  = 4'b0000;
        w_clr_dn  = 4'b0000;
        w_clr_car = 4'b0000;
        if (arrived) begin
            w_clr_car[level] = 1'b1;
            w_clr_up[level]  = (r_state != S_DOWN) || (level == 2'd0);
            w_clr_dn[level]  = (r_state != S_UP) || (level == 2'd3);
        end else begin
            w_clr_car = 4'b0000;
        end
    end

    // Pending request latches; clear dominates a same-cycle set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_up_q  <= 4'b0000;
            r_dn_q  <= 4'b0000;
            r_car_q <= 4'b0000;
        end else begin
            r_up_q  <= (r_up_q  | w_set[3:0])  & ~w_clr_up;
            r_dn_q  <= (r_dn_q  | w_set[7:4])  & ~w_clr_dn;
            r_car_q <= (r_car_q | w_set[11:8]) & ~w_clr_car;
        end
    end

    // Ascending scan keeps the highest match, descending scan keeps the lowest
    always_comb begin
        w_above  = 1'b0;
        w_below  = 1'b0;
        w_up_pri = 2'd0;
        w_up_alt = 2'd0;
        w_dn_pri = 2'd0;
        w_dn_alt = 2'd0;
        w_up_hit = 1'b0;
        w_dn_hit = 1'b0;
        for (int f = 0; f < FLOORS; f++) begin
            w_above  = w_above | (w_pend[f] & (f > int'(level)));
            w_below  = w_below | (w_pend[f] & (f < int'(level)));
            w_up_alt = ((f > int'(level)) && r_dn_q[f]) ? 2'(f) : w_up_alt;
            w_dn_hit = w_dn_hit | ((f < int'(level)) && (r_car_q[f] || r_dn_q[f]));
            w_dn_pri = ((f < int'(level)) && (r_car_q[f] || r_dn_q[f])) ? 2'(f) : w_dn_pri;
        end
        for (int f = FLOORS - 1; f >= 0; f--) begin
            w_up_hit = w_up_hit | ((f > int'(level)) && (r_car_q[f] || r_up_q[f]));
            w_up_pri = ((f > int'(level)) && (r_car_q[f] || r_up_q[f])) ? 2'(f) : w_up_pri;
            w_dn_alt = ((f < int'(level)) && r_up_q[f]) ? 2'(f) : w_dn_alt;
        end
    end

    assign w_up_tgt = w_up_hit ? w_up_pri : w_up_alt;
    assign w_dn_tgt = w_dn_hit ? w_dn_pri : w_dn_alt;

    // SCAN direction FSM with registered target and valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_target <= 2'd0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_here) begin
                        r_target <= level;
                        r_valid  <= 1'b1;
                    end else if (w_above) begin
                        r_state  <= S_UP;
                        r_target <= w_up_tgt;
                        r_valid  <= 1'b1;
                    end else if (w_below) begin
                        r_state  <= S_DOWN;
                        r_target <= w_dn_tgt;
                        r_valid  <= 1'b1;
                    end else begin
                        r_valid  <= 1'b0;
                    end
                end
                S_UP: begin
                    if (w_above) begin
                        r_target <= w_up_tgt;
                        r_valid  <= 1'b1;
                    end else if (w_below) begin
                        r_state  <= S_DOWN;
                        r_target <= w_dn_tgt;
                        r_valid  <= 1'b1;
                    end else begin
                        r_state  <= S_IDLE;
                        r_valid  <= 1'b0;
                    end
                end
                S_DOWN: begin
                    if (w_below) begin
                        r_target <= w_dn_tgt;
                        r_valid  <= 1'b1;
                    end else if (w_above) begin
                        r_state  <= S_UP;
                        r_target <= w_up_tgt;
                        r_valid  <= 1'b1;
                    end else begin
                        r_state  <= S_IDLE;
                        r_valid  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign target       = r_target;
    assign target_valid = r_valid;
    assign dir          = r_state;
    assign pending      = w_pend;

endmodule

// File: tb/tb_floor_request_queue.sv
// Directed bench for floor_request_queue with hand-computed expectations.
// Honors REQ_DEBOUNCE_EN so the same vectors apply to either build.
module tb_floor_request_queue;
`ifdef REQ_DEBOUNCE_EN
    localparam int LAT  = 6;
    localparam int HOLD = 4;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 1;
`endif
    localparam int HOLD2 = (HOLD > 2) ? HOLD : 2;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] call_up;
    logic [3:0] call_down;
    logic [3:0] car_call;
    logic [1:0] level;
    logic       arrived;
    logic [1:0] target;
    logic       target_valid;
    logic [1:0] dir;
    logic [3:0] pending;

    int n_tests;
    int n_fail;

    floor_request_queue dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .call_up      (call_up),
        .call_down    (call_down),
        .car_call     (car_call),
        .level        (level),
        .arrived      (arrived),
        .target       (target),
        .target_valid (target_valid),
        .dir          (dir),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Drive buttons at the next edge, release after 'hold' edges, return after 'total' edges.
    task automatic press(input logic [3:0] up, input logic [3:0] dn, input logic [3:0] car,
                         input int hold, input int total);
        call_up = up;
        call_down = dn;
        car_call = car;
        for (int i = 0; i < total; i++) begin
            tick();
            if (i == hold - 1) begin
                call_up = 4'b0000;
                call_down = 4'b0000;
                car_call = 4'b0000;
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        enable = 1'b1;
        call_up = 4'b0000;
        call_down = 4'b0000;
        car_call = 4'b0000;
        level = 2'd0;
        arrived = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_val("rst_target", 8'(target), 8'h00);
        check_val("rst_valid", 8'(target_valid), 8'h00);
        check_val("rst_dir", 8'(dir), 8'h00);
        check_val("rst_pending", 8'(pending), 8'h00);

        // Basic press latency from level 0
        press(4'b0000, 4'b0000, 4'b0100, HOLD2, LAT);
        check_val("lat_pend_early", 8'(pending), 8'h00);
        tick();
        check_val("lat_pend", 8'(pending), 8'h04);
        check_val("lat_valid_early", 8'(target_valid), 8'h00);
        tick();
        check_val("lat_dir", 8'(dir), 8'h01);
        check_val("lat_target", 8'(target), 8'h02);
        check_val("lat_valid", 8'(target_valid), 8'h01);

        // Preemption by a closer car call
        do_reset();
        level = 2'd0;
        press(4'b0000, 4'b0000, 4'b1000, HOLD, LAT + 2);
        check_val("pre_target3", 8'(target), 8'h03);
        press(4'b0000, 4'b0000, 4'b0010, HOLD, LAT + 2);
        check_val("pre_target1", 8'(target), 8'h01);
        check_val("pre_pend", 8'(pending), 8'h0a);
        level = 2'd1;
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        check_val("pre_arr_pend", 8'(pending), 8'h08);
        tick();
        check_val("pre_arr_target", 8'(target), 8'h03);
        check_val("pre_arr_dir", 8'(dir), 8'h01);

        // Reversal at the top; down call kept while passing upward
        do_reset();
        level = 2'd0;
        press(4'b0000, 4'b0010, 4'b1000, HOLD, LAT + 2);
        check_val("rev_target3", 8'(target), 8'h03);
        level = 2'd1;
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        check_val("rev_keep_dn", 8'(pending), 8'h0a);
        level = 2'd3;
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        check_val("rev_pend_top", 8'(pending), 8'h02);
        tick();
        check_val("rev_dir", 8'(dir), 8'h02);
        check_val("rev_target", 8'(target), 8'h01);
        level = 2'd1;
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        check_val("rev_pend_done", 8'(pending), 8'h00);
        tick();
        check_val("rev_dir_idle", 8'(dir), 8'h00);
        check_val("rev_valid_idle", 8'(target_valid), 8'h00);

        // Set and clear in the same cycle: clear wins
        do_reset();
        level = 2'd2;
        press(4'b0000, 4'b0000, 4'b0100, HOLD, LAT);
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        check_val("same_cycle_pend", 8'(pending), 8'h00);
        tick();
        tick();
        check_val("same_cycle_valid", 8'(target_valid), 8'h00);

        // Presses ignored while disabled; nonexistent hall buttons ignored
        enable = 1'b0;
        press(4'b0010, 4'b0000, 4'b0000, HOLD, LAT + 2);
        check_val("disabled_pend", 8'(pending), 8'h00);
        enable = 1'b1;
        press(4'b1000, 4'b0001, 4'b0000, HOLD, LAT + 2);
        check_val("masked_pend", 8'(pending), 8'h00);

        // A held button latches once only
        car_call = 4'b0001;
        repeat (LAT + 2) tick();
        check_val("hold_pend", 8'(pending), 8'h01);
        check_val("hold_dir", 8'(dir), 8'h02);
        check_val("hold_target", 8'(target), 8'h00);
        level = 2'd0;
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        repeat (LAT + 2) tick();
        check_val("hold_once", 8'(pending), 8'h00);
        car_call = 4'b0000;

        // Reset mid-travel flushes state and presses in flight
        do_reset();
        level = 2'd0;
        press(4'b0000, 4'b0000, 4'b1010, HOLD, LAT + 2);
        check_val("mid_pend", 8'(pending), 8'h0a);
        check_val("mid_dir", 8'(dir), 8'h01);
        call_up = 4'b0100;
        tick();
        call_up = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mid_rst_target", 8'(target), 8'h00);
        check_val("mid_rst_valid", 8'(target_valid), 8'h00);
        check_val("mid_rst_dir", 8'(dir), 8'h00);
        check_val("mid_rst_pend", 8'(pending), 8'h00);
        repeat (LAT + 3) tick();
        check_val("mid_flushed", 8'(pending), 8'h00);

`ifdef REQ_DEBOUNCE_EN
        // Short pulse rejected, long pulse accepted six edges after it rises
        press(4'b0000, 4'b0000, 4'b0100, 2, 10);
        check_val("deb_short", 8'(pending), 8'h00);
        press(4'b0000, 4'b0000, 4'b0100, 4, 6);
        check_val("deb_long_early", 8'(pending), 8'h00);
        tick();
        check_val("deb_long", 8'(pending), 8'h04);
`else
        // A single-cycle pulse registers
        press(4'b0000, 4'b0000, 4'b0100, 1, LAT + 1);
        check_val("pulse1_pend", 8'(pending), 8'h04);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/floor_request_queue.md
# floor_request_queue

Hall- and car-call request stage feeding the elevator `Interface` controller. Synchronizes and edge-detects raw floor buttons, latches them as pending requests, and picks the next target floor using a SCAN (collective) policy from the car's current `level` and travel direction. Pending requests clear when the controller reports arrival. Sits directly upstream of `Interface`, between the board buttons and the motion/door FSM.

## Interface
- `FLOORS`, 4: number of floors. Fixed at 4 here; `level`/`target` are 2 bits wide.
- `DEBOUNCE_CYCLES`, 3: consecutive stable-high cycles needed to accept a press. Used only with `REQ_DEBOUNCE_EN`.
- `clk` in 1: single clock; all state on the rising edge.
- `reset` in 1: synchronous, active-high. Clears every register.
- `enable` in 1: 1 = accept new presses. 0 = presses ignored; pending requests and scheduling keep running.
- `call_up` in 4: hall up buttons, bit n = floor n. Bit 3 is ignored.
- `call_down` in 4: hall down buttons. Bit 0 is ignored.
- `car_call` in 4: in-car floor buttons.
- `level` in 2: current car floor from `Interface`.
- `arrived` in 1: one-cycle pulse from `Interface` when the doors open at `level`.
- `target` out 2: floor the car must go to next.
- `target_valid` out 1: `target` is meaningful.
- `dir` out 2: 00 IDLE, 01 UP, 10 DOWN. 11 is never driven.
- `pending` out 4: per-floor OR of all latched requests.

## Operation
- Input path: each of the 12 button bits goes through a 2-FF synchronizer, then a rising-edge detector. An accepted edge sets the matching pending bit (`up_q`, `dn_q` or `car_q`) if `enable`=1. Holding a button sets its bit once only.
- Clearing on `arrived`:
  - `car_q[level]` always clears.
  - `up_q[level]` clears when `dir`≠DOWN, or when `level`=0.
  - `dn_q[level]` clears when `dir`≠UP, or when `level`=3.
- Set and clear on the same bit in the same cycle: clear wins.
- Definitions used by the scheduler:
  - above = any pending floor > `level`.
  - below = any pending floor < `level`.
  - here = pending[`level`].
- FSM states: IDLE, UP, DOWN; the state is output on `dir`.
  - IDLE, here=1: `target`=`level`, `target_valid`=1, stay IDLE.
  - IDLE, here=0 and above: go UP.
  - IDLE, here=0, no above, below: go DOWN.
  - IDLE, nothing pending: `target_valid`=0.
  - UP, above: `target` = lowest floor > `level` with `car_q`|`up_q` set. If no such floor, `target` = highest floor > `level` with `dn_q` set.
  - UP, no above, below: go DOWN.
  - UP, no above, no below: go IDLE.
  - DOWN mirrors UP: `target` = highest floor < `level` with `car_q`|`dn_q` set, else lowest floor < `level` with `up_q` set.
  - DOWN, no below, above: go UP.
  - DOWN, no below, no above: go IDLE.
- `target_valid`=1 whenever `target` has been computed from a nonempty pending set.
- `level` changes mid-travel re-evaluate `target` on the next cycle. A new call closer in the travel direction preempts the current target.
- Out-of-range `level` cannot occur (2 bits, 4 floors).

## Timing
- Reset values: `target`=0, `target_valid`=0, `dir`=00, `pending`=0000. All pending, synchronizer, edge and debounce flops are 0.
- Press latency, without debounce:
  - button high at edge k: pending bit set at edge k+3.
  - `pending` visible after edge k+3.
  - `target`/`target_valid`/`dir` updated after edge k+4.
- Arrival latency:
  - `arrived` sampled at edge k: bit cleared at edge k.
  - FSM and `target` updated at edge k+1.
- `dir` changes at most once per cycle. IDLE→UP→DOWN takes two cycles minimum.
- `reset` high at any edge overrides everything: outputs return to reset values at that edge. This includes mid-travel and presses in the synchronizer pipeline.

## Configuration
- `REQ_DEBOUNCE_EN` defined: per-bit counter after the synchronizer. An edge is accepted only after `DEBOUNCE_CYCLES` consecutive high samples, and the counter resets on any low sample. Press latency becomes 2+`DEBOUNCE_CYCLES`+1 cycles to pending. A high pulse shorter than `DEBOUNCE_CYCLES` cycles is ignored.
- Not defined: no counters; the first synchronized high is accepted. A one-cycle pulse registers.

## Test plan
- Reset then `car_call`=0100 pulsed for 2 cycles, `level`=0 → `pending`=0100 on cycle 3; `dir`=01, `target`=2, `target_valid`=1 on cycle 4.
- Preemption: `level`=0, UP toward 3 (`car_q`=1000); press `car_call[1]` → `target` switches 3→1. Pulse `arrived` with `level`=1 → `pending`=1000, `target`=3, `dir`=01.
- Reversal: `level`=3, `dir`=UP, only `dn_q[1]` pending, `arrived` pulse → `dir`=10, `target`=1. A further `arrived` at `level`=1 → `pending`=0, `dir`=00, `target_valid`=0.
- Same-cycle set/clear: `car_call[2]` edge coincides with `arrived` at `level`=2 → bit 2 stays 0. With `enable`=0 a press on floor 1 → `pending` unchanged.
- Reset mid-operation: pending 1010, `dir`=01; assert `reset` for one cycle → all outputs 0 next cycle; a button held through reset does not register.
- With `REQ_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=3: 2-cycle pulse → no request. 4-cycle pulse → pending bit set 6 cycles after the rising input.
